// File: rtl/hp_event_scheduler.sv
// rtl/hp_event_scheduler.sv - player HP event scheduler (hit/heal sequencing, i-frames, death)
//
// Purpose:
//   Edge-detects four collision sources, latches them as pending events and
//   serves one per slot by fixed priority Big > B1 > B2 > GB. Damage saturates
//   HP at 0 and opens an invulnerability window. Heal saturates at HP_MAX.
//   Reaching 0 HP enters DEAD, which only reset leaves.
//   Optional build macro HP_REGEN_EN adds +1 HP per REGEN_PERIOD idle cycles.
//
// Ports:
//   Pclk            in   1   system clock, all logic on posedge
//   reset           in   1   asynchronous active-high reset
//   isCollisionB1   in   1   bullet 1 collision level (damage DMG_SMALL)
//   isCollisionB2   in   1   bullet 2 collision level (damage DMG_SMALL)
//   isCollisionBig  in   1   big bullet collision level (damage DMG_BIG)
//   isCollisionGB   in   1   green bullet collision level (heal HEAL_AMT)
//   state_game      in   2   game phase, 2'd1 re-arms the damage sources
//   hp              out  10  current HP, 0..HP_MAX
//   character_alive out  1   drops to 0 once HP reaches 0
//   hit_flash       out  1   high during the invulnerability window
//   dead_pulse      out  1   one-cycle pulse on entry to DEAD
//   ack             out  4   one-cycle grant {GB,Big,B2,B1} when an event is applied

module hp_event_scheduler #(
  parameter logic [9:0]  HP_MAX        = 10'd150,
  parameter logic [9:0]  DMG_SMALL     = 10'd30,
  parameter logic [9:0]  DMG_BIG       = 10'd60,
  parameter logic [9:0]  HEAL_AMT      = 10'd60,
  parameter logic [23:0] IFRAME_CYCLES = 24'd12_500_000,
  parameter logic [23:0] REGEN_PERIOD  = 24'd25_000_000
) (
  input  logic       Pclk,
  input  logic       reset,
  input  logic       isCollisionB1,
  input  logic       isCollisionB2,
  input  logic       isCollisionBig,
  input  logic       isCollisionGB,
  input  logic [1:0] state_game,
  output logic [9:0] hp,
  output logic       character_alive,
  output logic       hit_flash,
  output logic       dead_pulse,
  output logic [3:0] ack
);

  localparam logic [1:0] IDX_B1  = 2'd0;
  localparam logic [1:0] IDX_B2  = 2'd1;
  localparam logic [1:0] IDX_BIG = 2'd2;
  localparam logic [1:0] IDX_GB  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_IFRAME,
    S_DEAD
  } state_t;

  state_t      state;
  logic [3:0]  prev_in;
  logic [3:0]  pending;
  logic [3:0]  armed;
  logic [1:0]  grant;
  logic [23:0] iframe_cnt;

  logic [3:0]  in_vec;
  logic [3:0]  rise;
  logic [1:0]  pick;
  logic [3:0]  grant_mask;
  logic [3:0]  armed_next;
  logic [9:0]  dmg;
  logic [9:0]  dmg_hp;
  logic [10:0] heal_sum;
  logic [9:0]  heal_hp;

  assign in_vec = {isCollisionGB, isCollisionBig, isCollisionB2, isCollisionB1};

  // A disarmed source never produces an event, even on a clean edge.
  assign rise = in_vec & ~prev_in & armed;

  assign grant_mask = 4'b0001 << grant;

  always_comb begin
    pick = IDX_GB;
    if (pending[IDX_BIG])
      pick = IDX_BIG;
    else if (pending[IDX_B1])
      pick = IDX_B1;
    else if (pending[IDX_B2])
      pick = IDX_B2;
  end

  always_comb begin
    dmg = (grant == IDX_BIG) ? DMG_BIG : DMG_SMALL;
    dmg_hp = (hp > dmg) ? (hp - dmg) : 10'd0;
    // Heal is summed one bit wider so the clamp sees the true total.
    heal_sum = {1'b0, hp} + {1'b0, HEAL_AMT};
    heal_hp = (heal_sum > {1'b0, HP_MAX}) ? HP_MAX : heal_sum[9:0];
  end

  // The served source is disarmed; a new-round phase re-arms the damage
  // sources afterwards, so re-arm wins in the same cycle. GB is never re-armed.
  always_comb begin
    armed_next = armed;
    if (state == S_APPLY)
      armed_next = armed_next & ~grant_mask;
    if (state != S_DEAD && state_game == 2'd1)
      armed_next = armed_next | 4'b0111;
  end

`ifdef HP_REGEN_EN
  logic [23:0] regen_cnt;
`else
  logic unused_regen_period;
  assign unused_regen_period = ^REGEN_PERIOD;
`endif

  always_ff @(posedge Pclk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      prev_in         <= 4'b0000;
      pending         <= 4'b0000;
      armed           <= 4'b1111;
      grant           <= IDX_B1;
      iframe_cnt      <= 24'd0;
      hp              <= HP_MAX;
      character_alive <= 1'b1;
      hit_flash       <= 1'b0;
      dead_pulse      <= 1'b0;
      ack             <= 4'b0000;
`ifdef HP_REGEN_EN
      regen_cnt       <= 24'd0;
`endif
    end else begin
      prev_in    <= in_vec;
      armed      <= armed_next;
      ack        <= 4'b0000;
      dead_pulse <= 1'b0;

      case (state)
        S_IDLE: begin
          pending <= pending | rise;
          if (pending != 4'b0000) begin
            grant <= pick;
            state <= S_APPLY;
          end
`ifdef HP_REGEN_EN
          if (pending != 4'b0000 || hp >= HP_MAX) begin
            regen_cnt <= 24'd0;
          end else if (regen_cnt == REGEN_PERIOD - 24'd1) begin
            regen_cnt <= 24'd0;
            hp        <= hp + 10'd1;
          end else begin
            regen_cnt <= regen_cnt + 24'd1;
          end
`endif
        end

        S_APPLY: begin
          pending <= (pending | rise) & ~grant_mask;
          ack     <= grant_mask;
          if (grant == IDX_GB) begin
            hp    <= heal_hp;
            state <= S_IDLE;
          end else begin
            hp <= dmg_hp;
            if (dmg_hp == 10'd0) begin
              state           <= S_DEAD;
              character_alive <= 1'b0;
              dead_pulse      <= 1'b1;
            end else begin
              state      <= S_IFRAME;
              hit_flash  <= 1'b1;
              iframe_cnt <= IFRAME_CYCLES - 24'd1;
            end
          end
`ifdef HP_REGEN_EN
          regen_cnt <= 24'd0;
`endif
        end

        S_IFRAME: begin
          // Damage arriving while invulnerable is dropped outright, including
          // same-cycle damage that lost arbitration; a heal waits its turn.
          pending <= {pending[IDX_GB] | rise[IDX_GB], 3'b000};
          if (iframe_cnt == 24'd0) begin
            state     <= S_IDLE;
            hit_flash <= 1'b0;
          end else begin
            iframe_cnt <= iframe_cnt - 24'd1;
          end
`ifdef HP_REGEN_EN
          regen_cnt <= 24'd0;
`endif
        end

        S_DEAD: begin
          pending <= 4'b0000;
`ifdef HP_REGEN_EN
          regen_cnt <= 24'd0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_event_scheduler.sv
// tb/tb_hp_event_scheduler.sv - scoreboard bench for hp_event_scheduler

module tb_hp_event_scheduler;

  logic       Pclk;
  logic       reset;
  logic       b1, b2, big, gb;
  logic [1:0] state_game;
  logic [9:0] hp;
  logic       character_alive;
  logic       hit_flash;
  logic       dead_pulse;
  logic [3:0] ack;

  hp_event_scheduler #(
    .IFRAME_CYCLES(24'd8),
    .REGEN_PERIOD (24'd16)
  ) dut (
    .Pclk           (Pclk),
    .reset          (reset),
    .isCollisionB1  (b1),
    .isCollisionB2  (b2),
    .isCollisionBig (big),
    .isCollisionGB  (gb),
    .state_game     (state_game),
    .hp             (hp),
    .character_alive(character_alive),
    .hit_flash      (hit_flash),
    .dead_pulse     (dead_pulse),
    .ack            (ack)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  typedef struct {
    logic [3:0] ack;
    int         hp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   dp_cnt = 0;

  int   m_hp;
  logic [3:0] m_armed;
  bit   m_dead;

  task automatic chk(input string name, input int got, input int expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Reference model: one event burst applied to a quiescent scheduler.
  task automatic m_heal();
    m_armed[3] = 1'b0;
    m_hp = (m_hp + 60 > 150) ? 150 : m_hp + 60;
    exp_q.push_back('{ack: 4'b1000, hp: m_hp});
  endtask

  task automatic model_event(input logic [3:0] e);
    logic [3:0] p;
    int d;
    int i;
    p = e & m_armed;
    if (m_dead || p == 4'b0000) return;
    if (p[2]) i = 2;
    else if (p[0]) i = 0;
    else if (p[1]) i = 1;
    else i = 3;
    if (i == 3) begin
      m_heal();
      return;
    end
    m_armed[i] = 1'b0;
    d = (i == 2) ? 60 : 30;
    m_hp = (m_hp > d) ? m_hp - d : 0;
    exp_q.push_back('{ack: 4'(1 << i), hp: m_hp});
    if (m_hp == 0) begin
      m_dead = 1'b1;
      return;
    end
    if (p[3]) m_heal();
  endtask

  always @(negedge Pclk) begin
    if (!reset) begin
      if (dead_pulse) dp_cnt++;
      if (ack != 4'b0000) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_value", int'(ack), int'(e.ack));
          chk("hp_at_ack", int'(hp), e.hp);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    {gb, big, b2, b1} = 4'b0000;
    state_game = 2'd0;
    repeat (2) @(negedge Pclk);
    m_hp = 150;
    m_armed = 4'b1111;
    m_dead = 1'b0;
    exp_q.delete();
    dp_cnt = 0;
    reset = 1'b0;
    @(negedge Pclk);
  endtask

  task automatic pulse(input logic [3:0] mask, input int len);
    model_event(mask);
    {gb, big, b2, b1} = mask;
    repeat (len) @(negedge Pclk);
    {gb, big, b2, b1} = 4'b0000;
    repeat (16) @(negedge Pclk);
  endtask

  task automatic rearm();
    if (!m_dead) m_armed[2:0] = 3'b111;
    state_game = 2'd1;
    @(negedge Pclk);
    state_game = 2'd0;
    @(negedge Pclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    {gb, big, b2, b1} = 4'b0000;
    state_game = 2'd0;

    // Reset values
    do_reset();
    chk("rst_hp", int'(hp), 150);
    chk("rst_alive", int'(character_alive), 1);
    chk("rst_flash", int'(hit_flash), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_dead_pulse", int'(dead_pulse), 0);

    // Single B1 pulse: latency, i-frame length, regen
    model_event(4'b0001);
    b1 = 1'b1;
    @(negedge Pclk);
    b1 = 1'b0;
    chk("lat_ack_k", int'(ack), 0);
    @(negedge Pclk);
    chk("lat_ack_k1", int'(ack), 0);
    chk("lat_hp_k1", int'(hp), 150);
    @(negedge Pclk);
    chk("lat_ack_k2", int'(ack), 1);
    chk("lat_hp_k2", int'(hp), 120);
    n = 0;
    while (hit_flash && n < 50) begin
      n++;
      @(negedge Pclk);
    end
    chk("iframe_len", n, 8);
    repeat (20) @(negedge Pclk);
`ifdef HP_REGEN_EN
    chk("regen_hp", int'(hp), 121);
    m_hp = 121;
`else
    chk("regen_hp", int'(hp), 120);
`endif
    pulse(4'b0001, 1);
    chk("b1_disarmed_hp", int'(hp), m_hp);

    // Simultaneous B1 + Big
    do_reset();
    pulse(4'b0101, 1);
    chk("b1_big_hp", int'(hp), 90);

    // Big x3 with re-arm -> death
    do_reset();
    pulse(4'b0100, 1);
    chk("big1_hp", int'(hp), 90);
    rearm();
    pulse(4'b0100, 1);
    chk("big2_hp", int'(hp), 30);
    rearm();
    pulse(4'b0100, 2);
    chk("big3_hp", int'(hp), 0);
    chk("dead_alive", int'(character_alive), 0);
    chk("dead_pulse_cnt", dp_cnt, 1);
    pulse(4'b1000, 1);
    chk("dead_gb_hp", int'(hp), 0);
    chk("dead_pulse_cnt2", dp_cnt, 1);

    // Heal arriving during i-frames is served afterwards
    do_reset();
    model_event(4'b0001);
    b1 = 1'b1;
    @(negedge Pclk);
    b1 = 1'b0;
    repeat (3) @(negedge Pclk);
    chk("heal_in_iframe_flash", int'(hit_flash), 1);
    pulse(4'b1000, 1);
    chk("heal_after_iframe_hp", int'(hp), 150);

    // Held-high input yields one event
    do_reset();
    pulse(4'b0010, 12);
    chk("held_b2_hp", int'(hp), 120);

    // Asynchronous reset in the middle of i-frames
    do_reset();
    model_event(4'b0001);
    b1 = 1'b1;
    @(negedge Pclk);
    b1 = 1'b0;
    repeat (4) @(negedge Pclk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_hp", int'(hp), 150);
    chk("async_rst_flash", int'(hit_flash), 0);
    chk("async_rst_alive", int'(character_alive), 1);
    do_reset();

`ifndef HP_REGEN_EN
    // Randomized bursts against the reference model
    for (int it = 0; it < 60; it++) begin
      if (m_dead) do_reset();
      if ($urandom_range(0, 4) == 0)
        rearm();
      else
        pulse(4'($urandom_range(1, 15)), int'($urandom_range(1, 3)));
      chk("rand_hp", int'(hp), m_hp);
      chk("rand_alive", int'(character_alive), m_dead ? 0 : 1);
    end
`endif

    repeat (4) @(negedge Pclk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
